// File: rtl/task_enqueue.sv
// -----------------------------------------------------------------------------
// task_enqueue
//
// Upstream stage of the RPU task distributor. Independent push requests
// (tree id + data) and pop requests (tree id) arrive over valid/ready and are
// packed into task words. A push and a pop accepted in the same cycle share
// one word (a combined push+pop word). Words are dealt round-robin, in strict
// order, over LEVEL lane FIFOs. The distributor drains each lane through a
// registered read port with one cycle of read latency.
//
// Task word layout, MSB first:
//   {push_bit, pop_bit, push_treeId, pop_treeId, push_data}
//   Fields of a request that was not accepted are zero.
//
// Ports
//   i_clk            clock, all state on the rising edge
//   i_arst           asynchronous reset, active-high
//   i_push_valid     push request valid
//   o_push_ready     push request accepted when valid & ready
//   i_push_treeId    tree targeted by the push
//   i_push_data      {payload, metadata, length} carried by the push
//   i_pop_valid      pop request valid
//   o_pop_ready      pop request accepted when valid & ready
//   i_pop_treeId     tree targeted by the pop
//   i_pop_TaskFIFO   per-lane read strobe from the distributor
//   o_TaskFIFO_data  per-lane registered read data
//   o_TaskFIFO_empty per-lane empty flag
//   o_lane_full      per-lane full flag
//
// Handshake: a request transfers on a rising edge where valid and ready are
// both high. Ready depends only on registered state (fullness of the lane
// the round-robin pointer selects) and on reset, never on either valid, so a
// source may hold valid and wait for ready without a combinational loop.
// A source keeps its payload stable while valid is high and not accepted.
// -----------------------------------------------------------------------------
module task_enqueue #(
    parameter  int PTW      = 16,
    parameter  int MTW      = 16,
    parameter  int PLW      = 8,
    parameter  int LEVEL    = 4,
    parameter  int TREE_NUM = 4,
    parameter  int DEPTH    = 16,
    localparam int TNB      = $clog2(TREE_NUM),
    localparam int DW       = PTW + MTW + PLW,
    localparam int TW       = DW + 2 * TNB + 2
) (
    input  logic             i_clk,
    input  logic             i_arst,
    input  logic             i_push_valid,
    output logic             o_push_ready,
    input  logic [TNB-1:0]   i_push_treeId,
    input  logic [DW-1:0]    i_push_data,
    input  logic             i_pop_valid,
    output logic             o_pop_ready,
    input  logic [TNB-1:0]   i_pop_treeId,
    input  logic [LEVEL-1:0] i_pop_TaskFIFO,
    output logic [TW-1:0]    o_TaskFIFO_data [0:LEVEL-1],
    output logic [LEVEL-1:0] o_TaskFIFO_empty,
    output logic [LEVEL-1:0] o_lane_full
);

    localparam int LB = $clog2(LEVEL);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    // -------------------------------------------------------------------------
    // Round-robin lane selection and acceptance
    // -------------------------------------------------------------------------
    logic [LB-1:0]    rr_ptr;
    logic [LEVEL-1:0] lane_full;
    logic [LEVEL-1:0] lane_empty;
    logic             lane_ready;
    logic             acc_push;
    logic             acc_pop;
    logic             acc_any;

    // Both inputs stall together on a full target lane: the pointer never
    // skips ahead, so words stay in strict arrival order across lanes.
    assign lane_ready   = !lane_full[rr_ptr] && !i_arst;
    assign o_push_ready = lane_ready;
    assign o_pop_ready  = lane_ready;

    assign acc_push = i_push_valid && lane_ready;
    assign acc_pop  = i_pop_valid && lane_ready;
    assign acc_any  = acc_push || acc_pop;

    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            rr_ptr <= '0;
        end else if (acc_any) begin
            // LEVEL is a power of two, so natural overflow is the modulo wrap.
            rr_ptr <= rr_ptr + LB'(1);
        end
    end

    // -------------------------------------------------------------------------
    // Task word assembly: unaccepted halves are zeroed so a push-only word has
    // no stale pop tree and a pop-only word carries no push data.
    // -------------------------------------------------------------------------
    logic [TNB-1:0] push_tree_f;
    logic [TNB-1:0] pop_tree_f;
    logic [DW-1:0]  push_data_f;
    logic [TW-1:0]  wr_word;

    always_comb begin
        push_tree_f = '0;
        pop_tree_f  = '0;
        push_data_f = '0;
        if (acc_push) begin
            push_tree_f = i_push_treeId;
            push_data_f = i_push_data;
        end
        if (acc_pop) begin
            pop_tree_f = i_pop_treeId;
        end
        wr_word = {acc_push, acc_pop, push_tree_f, pop_tree_f, push_data_f};
    end

    // -------------------------------------------------------------------------
    // Lane FIFOs
    // -------------------------------------------------------------------------
    for (genvar g = 0; g < LEVEL; g++) begin : g_lane
        logic [TW-1:0] mem [DEPTH];
        logic [AW-1:0] wr_ptr;
        logic [AW-1:0] rd_ptr;
        logic [AW:0]   count;
        logic [TW-1:0] rd_data;
        logic          wr_en;
        logic          rd_en;

        // Writes only ever target the selected lane, and that lane is never
        // full when acc_any is high, so no overflow guard is needed here.
        assign wr_en = acc_any && (rr_ptr == LB'(g));
        // Reads of an empty lane are dropped; data and pointers hold.
        assign rd_en = i_pop_TaskFIFO[g] && (count != '0);

        // Storage has no reset: contents are discarded by clearing the
        // pointers and count, which makes every old entry unreachable.
        always_ff @(posedge i_clk) begin
            if (wr_en) begin
                mem[wr_ptr] <= wr_word;
            end
        end

        always_ff @(posedge i_clk or posedge i_arst) begin
            if (i_arst) begin
                wr_ptr  <= '0;
                rd_ptr  <= '0;
                count   <= '0;
                rd_data <= '0;
            end else begin
                if (wr_en) begin
                    wr_ptr <= wr_ptr + AW'(1);
                end
                if (rd_en) begin
                    rd_ptr  <= rd_ptr + AW'(1);
                    rd_data <= mem[rd_ptr];
                end
                // Simultaneous write and read leaves the count unchanged.
                case ({wr_en, rd_en})
                    2'b10:   count <= count + (AW + 1)'(1);
                    2'b01:   count <= count - (AW + 1)'(1);
                    default: count <= count;
                endcase
            end
        end

        // A word written at edge t raises count at t, so empty falls in the
        // cycle after the accept and the earliest read is the following edge.
        assign lane_full[g]        = (count == FULL_CNT);
        assign lane_empty[g]       = (count == '0);
        assign o_TaskFIFO_data[g]  = rd_data;
    end

    assign o_TaskFIFO_empty = lane_empty;
    assign o_lane_full      = lane_full;

endmodule

// File: tb/tb_task_enqueue.sv
module tb_task_enqueue;

    localparam int PTW      = 16;
    localparam int MTW      = 16;
    localparam int PLW      = 8;
    localparam int LEVEL    = 4;
    localparam int TREE_NUM = 4;
    localparam int DEPTH    = 16;
    localparam int TNB      = 2;
    localparam int DW       = PTW + MTW + PLW;
    localparam int TW       = DW + 2 * TNB + 2;

    // ------------------------------------------------------------------
    // DUT signals
    // ------------------------------------------------------------------
    logic             i_clk;
    logic             i_arst;
    logic             i_push_valid;
    logic             o_push_ready;
    logic [TNB-1:0]   i_push_treeId;
    logic [DW-1:0]    i_push_data;
    logic             i_pop_valid;
    logic             o_pop_ready;
    logic [TNB-1:0]   i_pop_treeId;
    logic [LEVEL-1:0] i_pop_TaskFIFO;
    logic [TW-1:0]    o_TaskFIFO_data [0:LEVEL-1];
    logic [LEVEL-1:0] o_TaskFIFO_empty;
    logic [LEVEL-1:0] o_lane_full;

    task_enqueue #(
        .PTW(PTW), .MTW(MTW), .PLW(PLW),
        .LEVEL(LEVEL), .TREE_NUM(TREE_NUM), .DEPTH(DEPTH)
    ) dut (
        .i_clk           (i_clk),
        .i_arst          (i_arst),
        .i_push_valid    (i_push_valid),
        .o_push_ready    (o_push_ready),
        .i_push_treeId   (i_push_treeId),
        .i_push_data     (i_push_data),
        .i_pop_valid     (i_pop_valid),
        .o_pop_ready     (o_pop_ready),
        .i_pop_treeId    (i_pop_treeId),
        .i_pop_TaskFIFO  (i_pop_TaskFIFO),
        .o_TaskFIFO_data (o_TaskFIFO_data),
        .o_TaskFIFO_empty(o_TaskFIFO_empty),
        .o_lane_full     (o_lane_full)
    );

    // ------------------------------------------------------------------
    // Clock / reset
    // ------------------------------------------------------------------
    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    // ------------------------------------------------------------------
    // Scoreboard: one expected queue per lane plus the last word read
    // ------------------------------------------------------------------
    logic [TW-1:0] exp_q [LEVEL][$];
    logic [TW-1:0] last_data [LEVEL];
    logic [1:0]    mdl_rr;
    int            n_checks;
    int            n_errors;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [TW-1:0] mk_word(input logic pb, input logic qb,
                                              input logic [TNB-1:0] pt, input logic [TNB-1:0] qt,
                                              input logic [DW-1:0] d);
        return {pb, qb, pt, qt, d};
    endfunction

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic model_clear();
        for (int l = 0; l < LEVEL; l++) begin
            exp_q[l[1:0]].delete();
            last_data[l[1:0]] = '0;
        end
        mdl_rr = '0;
    endtask

    task automatic check_status(input string tag);
        for (int l = 0; l < LEVEL; l++) begin
            check($sformatf("%s empty%0d", tag, l), 64'(o_TaskFIFO_empty[l]),
                  64'(exp_q[l[1:0]].size() == 0));
            check($sformatf("%s full%0d", tag, l), 64'(o_lane_full[l]),
                  64'(exp_q[l[1:0]].size() == DEPTH));
        end
        check({tag, " push_ready"}, 64'(o_push_ready), 64'(exp_q[mdl_rr].size() < DEPTH));
        check({tag, " pop_ready"}, 64'(o_pop_ready), 64'(exp_q[mdl_rr].size() < DEPTH));
    endtask

    // ------------------------------------------------------------------
    // Driver: one cycle of push/pop requests and an optional lane read
    // ------------------------------------------------------------------
    task automatic send(input string tag,
                        input logic pv, input logic [TNB-1:0] pt, input logic [DW-1:0] pd,
                        input logic qv, input logic [TNB-1:0] qt,
                        input logic rd_en, input logic [1:0] rd_lane);
        logic exp_acc;
        logic [TW-1:0] w;
        i_push_valid  = pv;
        i_push_treeId = pt;
        i_push_data   = pd;
        i_pop_valid   = qv;
        i_pop_treeId  = qt;
        if (rd_en) i_pop_TaskFIFO[rd_lane] = 1'b1;
        exp_acc = (pv || qv) && (exp_q[mdl_rr].size() < DEPTH);
        // Read uses the pre-edge contents, so model it before the write.
        if (rd_en && exp_q[rd_lane].size() > 0) begin
            last_data[rd_lane] = exp_q[rd_lane].pop_front();
        end
        if (exp_acc) begin
            w = mk_word(pv, qv, pv ? pt : '0, qv ? qt : '0, pv ? pd : '0);
            exp_q[mdl_rr].push_back(w);
            mdl_rr = mdl_rr + 2'd1;
        end
        step();
        i_push_valid   = 1'b0;
        i_pop_valid    = 1'b0;
        i_push_treeId  = '0;
        i_pop_treeId   = '0;
        i_push_data    = '0;
        i_pop_TaskFIFO = '0;
        if (rd_en) begin
            check({tag, " data"}, 64'(o_TaskFIFO_data[rd_lane]), 64'(last_data[rd_lane]));
        end
        check_status(tag);
    endtask

    task automatic do_push(input logic [TNB-1:0] t, input logic [DW-1:0] d);
        send("push", 1'b1, t, d, 1'b0, '0, 1'b0, 2'd0);
    endtask

    task automatic do_pop(input logic [TNB-1:0] t);
        send("pop", 1'b0, '0, '0, 1'b1, t, 1'b0, 2'd0);
    endtask

    task automatic do_read(input logic [1:0] l);
        send("read", 1'b0, '0, '0, 1'b0, '0, 1'b1, l);
    endtask

    task automatic drain_all();
        for (int l = 0; l < LEVEL; l++) begin
            while (exp_q[l[1:0]].size() > 0) do_read(l[1:0]);
        end
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    logic [1:0]    tgt;
    logic [1:0]    cur;
    logic [TW-1:0] held;
    int            k;

    initial begin
        n_checks       = 0;
        n_errors       = 0;
        i_arst         = 1'b1;
        i_push_valid   = 1'b0;
        i_pop_valid    = 1'b0;
        i_push_treeId  = '0;
        i_pop_treeId   = '0;
        i_push_data    = '0;
        i_pop_TaskFIFO = '0;
        model_clear();

        // Power-on reset
        repeat (2) step();
        check("rst push_ready", 64'(o_push_ready), 64'(0));
        check("rst pop_ready", 64'(o_pop_ready), 64'(0));
        check("rst empty", 64'(o_TaskFIFO_empty), 64'(4'hF));
        check("rst full", 64'(o_lane_full), 64'(4'h0));
        i_arst = 1'b0;
        step();
        check_status("post_rst");

        // Push only: tree 2, data 0xA5 lands in lane 0
        do_push(2'd2, 40'hA5);
        check("push empty0", 64'(o_TaskFIFO_empty[0]), 64'(0));
        do_read(2'd0);
        check("push word", 64'(o_TaskFIFO_data[0]), 64'({1'b1, 1'b0, 2'd2, 2'd0, 40'hA5}));

        // Push + pop in one cycle form a single word in lane 1
        send("pp", 1'b1, 2'd1, 40'h11, 1'b1, 2'd3, 1'b0, 2'd0);
        check("pp empty2", 64'(o_TaskFIFO_empty[2]), 64'(1));
        do_read(2'd1);
        check("pp word", 64'(o_TaskFIFO_data[1]), 64'({1'b1, 1'b1, 2'd1, 2'd3, 40'h11}));

        // Reset held 3 cycles in the middle of traffic
        do_push(2'd0, 40'h1);
        do_push(2'd0, 40'h2);
        i_push_valid = 1'b1;
        i_push_data  = 40'h3;
        i_arst       = 1'b1;
        #1;
        check("arst empty", 64'(o_TaskFIFO_empty), 64'(4'hF));
        check("arst data0", 64'(o_TaskFIFO_data[0]), 64'(0));
        check("arst data1", 64'(o_TaskFIFO_data[1]), 64'(0));
        for (int c = 0; c < 3; c++) begin
            step();
            check("arst push_ready", 64'(o_push_ready), 64'(0));
            check("arst pop_ready", 64'(o_pop_ready), 64'(0));
            check("arst full", 64'(o_lane_full), 64'(4'h0));
        end
        i_push_valid = 1'b0;
        i_push_data  = '0;
        i_arst       = 1'b0;
        model_clear();
        step();
        check_status("arst_rel");

        // Round-robin: six pops go to lanes 0,1,2,3,0,1
        for (int i = 0; i < 6; i++) do_pop(2'(i));
        check("rr empty", 64'(o_TaskFIFO_empty), 64'(4'h0));
        do_read(2'd0);
        check("rr lane0 cnt2", 64'(o_TaskFIFO_empty[0]), 64'(0));
        do_read(2'd0);
        check("rr lane0 word2", 64'(o_TaskFIFO_data[0]), 64'({1'b0, 1'b1, 2'd0, 2'd0, 40'h0}));
        check("rr lane0 drained", 64'(o_TaskFIFO_empty[0]), 64'(1));
        do_read(2'd2);
        check("rr lane2 cnt1", 64'(o_TaskFIFO_empty[2]), 64'(1));
        drain_all();

        // Fill lane 0 to DEPTH while the other lanes drain
        k = 0;
        while (exp_q[0].size() < DEPTH) begin
            cur = mdl_rr;
            do_push(2'(k), 40'h100 + 40'(k));
            if (cur != 2'd0) do_read(cur);
            k++;
        end
        for (int i = 0; i < 3; i++) do_push(2'(i), 40'h200 + 40'(i));
        check("full lane0", 64'(o_lane_full[0]), 64'(1));
        check("full stall", 64'(o_push_ready), 64'(0));
        send("stall", 1'b1, 2'd3, 40'hDEAD, 1'b1, 2'd1, 1'b0, 2'd0);
        do_read(2'd0);
        check("full ready back", 64'(o_push_ready), 64'(1));
        do_push(2'd3, 40'hBEEF);
        check("refull lane0", 64'(o_lane_full[0]), 64'(1));
        drain_all();

        // Read of an empty lane is ignored
        held = o_TaskFIFO_data[2];
        do_read(2'd2);
        check("empty read data", 64'(o_TaskFIFO_data[2]), 64'(held));
        check("empty read flag", 64'(o_TaskFIFO_empty[2]), 64'(1));

        // Simultaneous write and read on a lane holding DEPTH-1 words
        tgt = mdl_rr;
        k   = 0;
        while (!(exp_q[tgt].size() == DEPTH - 1 && mdl_rr == tgt)) begin
            cur = mdl_rr;
            do_push(2'(k), 40'h300 + 40'(k));
            if (cur != tgt) do_read(cur);
            k++;
        end
        send("wr_rd", 1'b1, 2'd2, 40'hCAFE, 1'b0, '0, 1'b1, tgt);
        check("wr_rd not full", 64'(o_lane_full[tgt]), 64'(0));
        drain_all();
        check("final empty", 64'(o_TaskFIFO_empty), 64'(4'hF));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
